adc_sync_align_ctrl: RTL and testbench

Sequencer that runs the four-channel ADC sync check and, on failure, steps the capture alignment until the check passes. It drives the checker's detect window, samples the checker's result, and issues single-cycle slip requests to the B/C/D capture paths (A is the fixed reference) in a fixed rotation. It sits between the host control registers and the ADC interface (checker plus per-channel bitslip logic), all in the ADC data clock domain.

---
 rtl/adc_sync_align_ctrl.sv | 167 ++++++++++++++++
 tb/tb_adc_sync_align_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adc_sync_align_ctrl.sv
// adc_sync_align_ctrl
// Runs the four-channel ADC sync check and, while it fails, issues bitslip
// requests to the B/C/D capture paths in a fixed B, C, D rotation until the
// check passes or the attempt budget runs out. Everything is in the ADC data
// clock domain. All outputs are registered from the next-state decode.
//
// Handshake: start is a single-cycle request with no ready. It is accepted only
// in IDLE, LOCKED or FAIL. In any other state it is dropped silently, and busy
// tells the host whether a request will be taken.
module adc_sync_align_ctrl #(
   parameter int SETTLE_CYCLES = 64,
   parameter int WINDOW_W      = 16,
   parameter int MAX_TRY       = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WINDOW_W-1:0] window_len,
   output logic                detect_out,
   input  logic                adc_is_sync,
   output logic                slip_pulse,
   output logic [1:0]          slip_sel,
   output logic                busy,
   output logic                locked,
   output logic                fail,
   output logic [7:0]          try_cnt
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int CNT_W = (SET_W > WINDOW_W) ? SET_W : WINDOW_W;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(3);
   localparam logic [7:0]       MAX_TRY_C   = 8'(MAX_TRY);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_DETECT,
      ST_WAIT_RES,
      ST_EVAL,
      ST_SLIP,
      ST_LOCKED,
      ST_FAIL
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_next;
   logic [WINDOW_W-1:0] r_win;
   logic [WINDOW_W-1:0] w_win_next;
   logic [7:0]          r_try;
   logic [7:0]          w_try_next;
   logic [CNT_W-1:0]    w_win_last;
   logic [1:0]          w_sel_next;
   logic                w_busy_next;
   logic                r_detect;
   logic                r_slip;
   logic [1:0]          r_sel;
   logic                r_busy;
   logic                r_locked;
   logic                r_fail;

   // Latched window is never 0, so the last-cycle index cannot underflow.
   assign w_win_last = CNT_W'(r_win) - CNT_W'(1);

   // Next-state, phase counter, window latch and attempt count.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_win_next = r_win;
      w_try_next = r_try;
      case (r_state)
         ST_IDLE, ST_LOCKED, ST_FAIL: begin
            if (start) begin
               w_next     = ST_SETTLE;
               w_cnt_next = '0;
               w_win_next = (window_len == '0) ? WINDOW_W'(1) : window_len;
               w_try_next = 8'd0;
            end
         end
         ST_SETTLE: begin
            w_cnt_next = r_cnt + CNT_W'(1);
            if (r_cnt == SETTLE_LAST) begin
               w_next     = ST_DETECT;
               w_cnt_next = '0;
            end
         end
         ST_DETECT: begin
            w_cnt_next = r_cnt + CNT_W'(1);
            if (r_cnt == w_win_last) begin
               w_next     = ST_WAIT_RES;
               w_cnt_next = '0;
            end
         end
         ST_WAIT_RES: begin
            w_cnt_next = r_cnt + CNT_W'(1);
            if (r_cnt == WAIT_LAST) begin
               w_next     = ST_EVAL;
               w_cnt_next = '0;
            end
         end
         ST_EVAL: begin
            w_try_next = r_try + 8'd1;
            if (adc_is_sync)
               w_next = ST_LOCKED;
            else if (w_try_next == MAX_TRY_C)
               w_next = ST_FAIL;
            else
               w_next = ST_SLIP;
         end
         ST_SLIP: begin
            w_next     = ST_SETTLE;
            w_cnt_next = '0;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Output decode of the next state; the rotation comes from the attempt count.
   always_comb begin
      w_sel_next = 2'd0;
      if (w_next == ST_SLIP)
         w_sel_next = 2'(((w_try_next - 8'd1) % 8'd3) + 8'd1);
      w_busy_next = (w_next == ST_SETTLE) || (w_next == ST_DETECT) ||
                    (w_next == ST_WAIT_RES) || (w_next == ST_EVAL) ||
                    (w_next == ST_SLIP);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_win    <= WINDOW_W'(1);
         r_try    <= 8'd0;
         r_detect <= 1'b0;
         r_slip   <= 1'b0;
         r_sel    <= 2'd0;
         r_busy   <= 1'b0;
         r_locked <= 1'b0;
         r_fail   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= w_cnt_next;
         r_win    <= w_win_next;
         r_try    <= w_try_next;
         r_detect <= (w_next == ST_DETECT);
         r_slip   <= (w_next == ST_SLIP);
         r_sel    <= w_sel_next;
         r_busy   <= w_busy_next;
         r_locked <= (w_next == ST_LOCKED);
         r_fail   <= (w_next == ST_FAIL);
      end
   end

   assign detect_out = r_detect;
   assign slip_pulse = r_slip;
   assign slip_sel   = r_sel;
   assign busy       = r_busy;
   assign locked     = r_locked;
   assign fail       = r_fail;
   assign try_cnt    = r_try;

endmodule

// File: tb/tb_adc_sync_align_ctrl.sv
// Bench for adc_sync_align_ctrl. Expected outputs come from a timeline model:
// each attempt lasts S+W+6 cycles after the accepting edge, and the run ends
// after the first passing attempt or after MAX_TRY attempts.
module tb_adc_sync_align_ctrl;

   localparam int S  = 8;
   localparam int WW = 16;
   localparam int MT = 12;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [WW-1:0] window_len;
   logic          detect_out;
   logic          adc_is_sync;
   logic          slip_pulse;
   logic [1:0]    slip_sel;
   logic          busy;
   logic          locked;
   logic          fail;
   logic [7:0]    try_cnt;

   int            n_vec;
   int            n_err;
   int            run_id;
   logic [14:0]   exp_q[$];

   adc_sync_align_ctrl #(
      .SETTLE_CYCLES(S),
      .WINDOW_W(WW),
      .MAX_TRY(MT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .window_len(window_len),
      .detect_out(detect_out),
      .adc_is_sync(adc_is_sync),
      .slip_pulse(slip_pulse),
      .slip_sel(slip_sel),
      .busy(busy),
      .locked(locked),
      .fail(fail),
      .try_cnt(try_cnt)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {busy, detect_out, slip_pulse, slip_sel, locked, fail, try_cnt}
   function automatic logic [14:0] obs_vec();
      return {busy, detect_out, slip_pulse, slip_sel, locked, fail, try_cnt};
   endfunction

   // Expected outputs m edges after the accepting edge (m=0 is that edge).
   // first_pass is the 0-based attempt whose result is 1 (>= MT: never).
   function automatic logic [14:0] model(input int m, input int w, input int first_pass);
      int  p_len;
      int  n_att;
      int  k_end;
      int  a;
      int  p;
      int  tr;
      bit  pass;
      bit  det;
      bit  slp;
      logic [1:0] sel;
      p_len = S + w + 6;
      pass  = (first_pass < MT);
      n_att = pass ? first_pass + 1 : MT;
      k_end = (n_att - 1) * p_len + S + w + 5;
      if (m >= k_end)
         return {1'b0, 1'b0, 1'b0, 2'b00, pass, !pass, 8'(n_att)};
      a   = m / p_len;
      p   = m % p_len;
      det = (p >= S) && (p < S + w);
      slp = (p == S + w + 5);
      sel = slp ? 2'((a % 3) + 1) : 2'd0;
      tr  = a + ((p >= S + w + 5) ? 1 : 0);
      return {1'b1, det, slp, sel, 1'b0, 1'b0, 8'(tr)};
   endfunction

   // One run: start, then per-cycle compare against the model.
   task automatic run(input int w_in, input int first_pass, input bit noise);
      int w;
      int p_len;
      int n_att;
      int k_end;
      int p;
      w     = (w_in == 0) ? 1 : w_in;
      p_len = S + w + 6;
      n_att = (first_pass < MT) ? first_pass + 1 : MT;
      k_end = (n_att - 1) * p_len + S + w + 5;
      run_id++;
      window_len = WW'(w_in);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int m = 0; m <= k_end + 3; m++) begin
         exp_q.push_back(model(m, w, first_pass));
         check($sformatf("run%0d_m%0d", run_id, m), 32'(obs_vec()), 32'(exp_q.pop_front()));
         adc_is_sync = ((m / p_len) >= first_pass);
         if (noise) begin
            window_len = WW'($urandom);
            p = m % p_len;
            start = (m < k_end) &&
                    ((p == S + 1) || (p == S + w + 4) || ($urandom_range(0, 15) == 0));
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
   endtask

   task automatic idle_check(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_%0d", tag, i), 32'(obs_vec()), 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      run_id      = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      window_len  = '0;
      adc_is_sync = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_vals", 32'(obs_vec()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle_check("idle_after_reset", 3);

      run(16, 0, 1'b0);
      run(16, 4, 1'b0);
      run(5, 99, 1'b0);
      run(0, 0, 1'b1);
      run(3, 1, 1'b1);
      for (int i = 0; i < 6; i++)
         run($urandom_range(0, 12), $urandom_range(0, 14), 1'($urandom_range(0, 1)));

      // Reset in the middle of a detect window.
      window_len = WW'(10);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (S + 3) @(posedge clk);
      #1;
      check("pre_reset_detect", 32'(detect_out), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'(obs_vec()), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle_check("idle_after_midrun_reset", 5);
      run(4, 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
